compl_serial: RTL
=================

// Module: compl_serial
// PURPOSE
//  Multi-cycle, parametrised complementer: pass, one's or two's complement of a WIDTH-bit operand.
//  Processes CHUNK bits per cycle, LSB first, with a start/busy/done handshake.
//  Sits in the datapath beside the adder/ALU blocks. Serves as the shared negation unit for subtraction.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; WIDTH >= 2
//  CHUNK  2  bits processed per cycle; WIDTH % CHUNK == 0, else elaboration error ($error)
// PORTS
//  clk    in   1      single clock, rising edge
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when busy==0
//  mode   in   2      00 pass, 01 one's compl, 10 two's compl, 11 reserved (treated as pass)
//  inp    in   WIDTH  operand, captured with start
//  busy   out  1      operation in progress; start ignored while 1
//  done   out  1      one-cycle pulse: out/ovf updated this cycle
//  out    out  WIDTH  result register, holds last result until next done
//  ovf    out  1      two's-compl overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, out=0, ovf=0, internal regs cleared.
//   A reset during RUN aborts the operation and produces no done pulse.
//  FSM: IDLE -> RUN on start; RUN -> DONE after N=WIDTH/CHUNK chunk cycles.
//   DONE -> RUN if start, else DONE -> IDLE.
//  busy=1 exactly in RUN. done=1 exactly in DONE.
//   start in IDLE or DONE is accepted; start in RUN is ignored (no queuing).
//  Accept edge: latch inp into shift reg sh, latch mode, set chunk count k=0, set carry=1.
//  Each RUN edge: compute chunk c = sh[CHUNK-1:0]:
//   pass -> r = c
//   C1   -> r = ~c
//   C2   -> {carry,r} = ~c + carry (CHUNK+1-bit sum)
//   Then shift r into acc from MSB side, shift sh right by CHUNK, k++.
//   RUN exits on the edge where k==N-1.
//  Latency: start sampled at edge 0; done high in the cycle after edge N.
//   For the defaults (N=4), done is high after edge 4.
//   out/ovf are written on the same edge as DONE entry.
//   Back-to-back throughput: one result per N+1 cycles.
//  C2 of 0 gives 0 with final carry 1. The final carry is discarded; it is not an overflow.
//  out changes only on DONE entry. Between operations it is stable, including across IDLE.
// CONFIGURATION
//  Macro COMPL_SERIAL_OVF_EN:
//   Defined: ovf=1 at done iff mode==10 and operand==1<<(WIDTH-1), i.e. most negative.
//    out then equals the operand. ovf clears on the next done.
//    Tracked as: operand MSB latched at accept AND all lower bits zero (sticky zero-detect per chunk).
//   Undefined: detection logic compiled out, ovf tied to 0. Port list is unchanged.
// STRUCTURE
//  Shared header compl_defs.vh: mode localparams MODE_PASS/MODE_C1/MODE_C2, FSM state encodings.
//  Sub-module compl_chunk #(CHUNK): combinational slice with inputs c, mode, cin and outputs r, cout.
//   Instantiated once in compl_serial.
//  compl_serial holds the FSM, shift register sh, accumulator acc, counter k, carry reg and ovf logic.
// TESTING (WIDTH=8, CHUNK=2, macro defined unless noted)
//  C1 of 0x35 -> out=0xCA; done after edge 4; busy high for 4 cycles.
//  C2 of 0x01 -> 0xFF. C2 of 0x00 -> 0x00, ovf=0. Pass 0x5A -> 0x5A.
//  C2 of 0x80 -> out=0x80, ovf=1. Same test with macro undefined -> ovf=0.
//  start+0x0F while busy (2nd RUN cycle) -> ignored; result is of the first operand only.
//  start asserted in DONE cycle -> next op starts with no IDLE gap; two done pulses 5 cycles apart.
//  reset asserted mid-RUN -> immediately busy=0, out=0; no done pulse; next start works normally.

Source files
------------

// File: rtl/compl_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compl_serial_pkg
//  Description : Shared mode codes and FSM state encoding for the serial
//                complementer.
//  Revision    : 1.0  initial release
// ============================================================================
package compl_serial_pkg;

    // Operation select; 2'b11 is reserved and behaves as pass
    localparam logic [1:0] c_mode_pass = 2'b00;
    localparam logic [1:0] c_mode_c1   = 2'b01;
    localparam logic [1:0] c_mode_c2   = 2'b10;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/compl_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : compl_chunk
//  Description : Combinational CHUNK-bit complement slice. Pass, invert, or
//                invert-plus-carry (two's complement ripple step).
//  Revision    : 1.0  initial release
// ============================================================================
module compl_chunk
    import compl_serial_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] c,
    input  logic [1:0]       mode,
    input  logic             cin,
    output logic [CHUNK-1:0] r,
    output logic             cout
);

    logic [CHUNK:0] w_sum;

    // Select the slice result; carry only propagates in two's-complement mode
    always_comb begin
        r     = c;
        cout  = cin;
        w_sum = '0;
        case (mode)
            c_mode_c1: begin
                r = ~c;
            end
            c_mode_c2: begin
                w_sum = {1'b0, ~c} + {{CHUNK{1'b0}}, cin};
                r     = w_sum[CHUNK-1:0];
                cout  = w_sum[CHUNK];
            end
            default: begin
                r = c;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/compl_serial.sv
`default_nettype none
// ============================================================================
//  Module      : compl_serial
//  Description : Multi-cycle complementer (pass / one's / two's complement),
//                CHUNK bits per cycle, LSB first, start/busy/done handshake.
//                Optional macro COMPL_SERIAL_OVF_EN enables the two's
//                complement most-negative overflow flag; otherwise ovf = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module compl_serial
    import compl_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] inp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int c_n    = WIDTH / CHUNK;
    localparam int c_kw   = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_accw = (c_n > 1) ? (WIDTH - CHUNK) : 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_n - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("compl_serial: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_sh;
    logic [c_accw-1:0]   r_acc;
    logic [WIDTH-1:0]    r_out;
    logic [c_kw-1:0]     r_k;
    logic                r_carry;
    logic [1:0]          r_mode;

    logic                w_accept;
    logic                w_last;
    logic [CHUNK-1:0]    w_c;
    logic [CHUNK-1:0]    w_r;
    logic                w_cout;
    logic [WIDTH-1:0]    w_acc_next;
    logic [c_accw-1:0]   w_acc_keep;
    logic [WIDTH-1:0]    w_sh_next;

    // A start is taken whenever we are not mid-operation (IDLE or DONE)
    assign w_accept = start && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_k == c_k_last);
    assign w_c      = r_sh[CHUNK-1:0];

    compl_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .c    (w_c),
        .mode (r_mode),
        .cin  (r_carry),
        .r    (w_r),
        .cout (w_cout)
    );

    // Result bits enter from the MSB side; operand drains from the LSB side
    generate
        if (c_n == 1) begin : g_single
            assign w_acc_next = w_r;
            assign w_acc_keep = '0;
            assign w_sh_next  = '0;
        end else begin : g_multi
            assign w_acc_next = {w_r, r_acc};
            assign w_acc_keep = w_acc_next[WIDTH-1:CHUNK];
            assign w_sh_next  = {{CHUNK{1'b0}}, r_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_k == c_k_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one chunk per RUN cycle, publish on last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh    <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_mode  <= c_mode_pass;
        end else if (w_accept) begin
            r_sh    <= inp;
            r_acc   <= '0;
            r_mode  <= mode;
            r_k     <= '0;
            r_carry <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_sh    <= w_sh_next;
            r_acc   <= w_acc_keep;
            r_k     <= r_k + c_kw'(1);
            r_carry <= w_cout;
            if (w_last) r_out <= w_acc_next;
        end
    end

    assign out = r_out;

`ifdef COMPL_SERIAL_OVF_EN
    logic             r_msb;
    logic             r_zero;
    logic             r_ovf;
    logic [CHUNK-1:0] w_mask;
    logic             w_chunk_zero;

    // Final chunk carries the operand MSB, which is excluded from zero-detect
    assign w_mask       = w_last ? ~(CHUNK'(1) << (CHUNK - 1)) : '1;
    assign w_chunk_zero = ((w_c & w_mask) == '0);

    // Most-negative detect: MSB set and every lower bit zero, in C2 mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msb  <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_msb  <= inp[WIDTH-1];
            r_zero <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_zero <= r_zero & w_chunk_zero;
            if (w_last) r_ovf <= (r_mode == c_mode_c2) && r_msb && r_zero && w_chunk_zero;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire
